// File: rtl/clause_loader.sv
// clause_loader: packs a streamed CNF formula into clause-memory slice words,
// padding unused literal slots and unused slices with the reserved pad literal.
`default_nettype none

module clause_loader #(
    parameter  int NUM_CLAUSES           = 64,
    parameter  int VAR_ID_BITS           = 8,
    parameter  int NUM_CLAUSES_PER_CYCLE = 16,
    parameter  int NUM_VARS_PER_CLAUSE   = 3,
    localparam int LIT_W          = VAR_ID_BITS + 1,
    localparam int LITS_PER_SLICE = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
    localparam int SLICE_W        = LIT_W * LITS_PER_SLICE,
    localparam int NUM_SLICES     = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
    localparam int ADDR_W         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   lit_valid,
    output logic                   lit_ready,
    input  logic [VAR_ID_BITS-1:0] lit_var_id,
    input  logic                   lit_neg,
    input  logic                   lit_last,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_wr_addr,
    output logic [SLICE_W-1:0]     mem_wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int IDX_W = (LITS_PER_SLICE > 1) ? $clog2(LITS_PER_SLICE) : 1;

    localparam logic [LIT_W-1:0]   PAD_LIT   = {1'b0, {VAR_ID_BITS{1'b1}}};
    localparam logic [SLICE_W-1:0] PAD_SLICE = {LITS_PER_SLICE{PAD_LIT}};
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(LITS_PER_SLICE - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_SLICES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [SLICE_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]     lit_idx_q, lit_idx_d;
    logic [ADDR_W-1:0]    slice_addr_q, slice_addr_d;
    logic                 last_seen_q, last_seen_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            buf_q        <= PAD_SLICE;
            lit_idx_q    <= '0;
            slice_addr_q <= '0;
            last_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            lit_idx_q    <= lit_idx_d;
            slice_addr_q <= slice_addr_d;
            last_seen_q  <= last_seen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        lit_idx_d    = lit_idx_q;
        slice_addr_d = slice_addr_q;
        last_seen_d  = last_seen_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    buf_d        = PAD_SLICE;
                    lit_idx_d    = '0;
                    slice_addr_d = '0;
                    last_seen_d  = 1'b0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (lit_valid) begin
                    buf_d[int'(lit_idx_q) * LIT_W +: LIT_W] = {lit_neg, lit_var_id};
                    if ((lit_idx_q == LAST_IDX) || lit_last) begin
                        last_seen_d = lit_last;
                        state_d     = S_WRITE;
                    end else begin
                        lit_idx_d = lit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (slice_addr_q == LAST_ADDR) begin
                    state_d = last_seen_q ? S_DONE : S_ERROR;
                end else begin
                    slice_addr_d = slice_addr_q + ADDR_W'(1);
                    if (last_seen_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        lit_idx_d = '0;
                        buf_d     = PAD_SLICE;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_FLUSH: begin
                if (slice_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    slice_addr_d = slice_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode registered state only; FLUSH never reads the buffer.
    always_comb begin
        lit_ready   = (state_q == S_LOAD);
        mem_wr_en   = (state_q == S_WRITE) || (state_q == S_FLUSH);
        mem_wr_addr = mem_wr_en ? slice_addr_q : '0;
        mem_wr_data = '0;
        if (state_q == S_WRITE) begin
            mem_wr_data = buf_q;
        end else if (state_q == S_FLUSH) begin
            mem_wr_data = PAD_SLICE;
        end
        busy  = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_FLUSH);
        done  = (state_q == S_DONE);
        error = (state_q == S_ERROR);
    end

endmodule

`default_nettype wire

// File: tb/tb_clause_loader.sv
// tb_clause_loader: directed stimulus with a write scoreboard for clause_loader.
`default_nettype none

module tb_clause_loader;

    localparam int VB  = 8;
    localparam int LW  = VB + 1;
    localparam int LPS = 48;
    localparam int SW  = LW * LPS;
    localparam int NS  = 4;
    localparam int AW  = 2;

    localparam logic [LW-1:0] PAD_LIT = {1'b0, {VB{1'b1}}};
    localparam logic [SW-1:0] PAD     = {LPS{PAD_LIT}};

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          lit_valid = 1'b0;
    logic          lit_ready;
    logic [VB-1:0] lit_var_id = '0;
    logic          lit_neg = 1'b0;
    logic          lit_last = 1'b0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [SW-1:0] mem_wr_data;
    logic          busy, done, error;

    int  checks = 0;
    int  failures = 0;
    int  wr_cnt = 0;
    int  exp_wr = 0;
    wr_t exp_q[$];

    logic [SW-1:0] m_buf;
    int            m_idx;
    int            m_addr;

    clause_loader #(
        .NUM_CLAUSES(64), .VAR_ID_BITS(VB),
        .NUM_CLAUSES_PER_CYCLE(16), .NUM_VARS_PER_CLAUSE(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .lit_valid(lit_valid), .lit_ready(lit_ready),
        .lit_var_id(lit_var_id), .lit_neg(lit_neg), .lit_last(lit_last),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mem_wr_en) begin
            wr_t e;
            wr_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed addr=%0d expected no write", mem_wr_addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", SW'(mem_wr_addr), SW'(e.addr));
                chk("wr_data", mem_wr_data, e.data);
            end
        end
    end

    task automatic push_wr(input int a, input logic [SW-1:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        exp_q.push_back(e);
        exp_wr++;
    endtask

    task automatic model_start();
        m_buf  = PAD;
        m_idx  = 0;
        m_addr = 0;
    endtask

    task automatic model_accept(input logic [VB-1:0] id, input logic neg, input logic last,
                                output bit slice_done);
        slice_done = 1'b0;
        m_buf[m_idx*LW +: LW] = {neg, id};
        if (m_idx == LPS - 1 || last) begin
            slice_done = 1'b1;
            push_wr(m_addr, m_buf);
            if (last) begin
                for (int a = m_addr + 1; a < NS; a++) push_wr(a, PAD);
            end
            m_addr++;
            m_idx = 0;
            m_buf = PAD;
        end else begin
            m_idx++;
        end
    endtask

    // Called at a negedge; returns at the negedge following the handshake (or timeout).
    task automatic send(input logic [VB-1:0] id, input logic neg, input logic last,
                        input int gap, input bit expect_accept, input int limit);
        bit accepted;
        bit sd;
        int n;
        accepted = 1'b0;
        sd = 1'b0;
        n = 0;
        for (int g = 0; g < gap; g++) begin
            lit_valid  = 1'b0;
            lit_var_id = VB'($urandom);
            lit_neg    = 1'($urandom);
            lit_last   = 1'($urandom);
            @(negedge clk);
        end
        lit_valid  = 1'b1;
        lit_var_id = id;
        lit_neg    = neg;
        lit_last   = last;
        while (!accepted && n < limit) begin
            if (lit_ready === 1'b1) begin
                accepted = 1'b1;
                model_accept(id, neg, last, sd);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        lit_valid = 1'b0;
        lit_last  = 1'b0;
        chk(expect_accept ? "accept" : "reject", SW'(accepted), SW'(expect_accept));
        if (sd) chk("write_latency", SW'(mem_wr_en), SW'(1));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        model_start();
        chk("ready_after_start", SW'(lit_ready), SW'(1));
        chk("done_cleared", SW'(done), SW'(0));
        chk("error_cleared", SW'(error), SW'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done", SW'(done), SW'(1));
        chk("busy_idle", SW'(busy), SW'(0));
        chk("write_count", SW'(wr_cnt), SW'(exp_wr));
        chk("queue_drained", SW'(exp_q.size()), SW'(0));
    endtask

    initial begin
        int i;
        model_start();
        #1 reset = 1'b1;
        #2;
        chk("rst_ready", SW'(lit_ready), SW'(0));
        chk("rst_wr_en", SW'(mem_wr_en), SW'(0));
        chk("rst_wr_addr", SW'(mem_wr_addr), SW'(0));
        chk("rst_wr_data", mem_wr_data, SW'(0));
        chk("rst_flags", SW'({busy, done, error}), SW'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", SW'(lit_ready), SW'(0));

        // Full formula: 192 literals, last on the final one
        pulse_start();
        for (i = 0; i < 192; i++)
            send(VB'(i % 255), i[0], i == 191, 0, 1'b1, 60);
        wait_done();

        // Short formula: 5 literals then pad flushes
        pulse_start();
        for (i = 1; i <= 5; i++)
            send(VB'(i), i[1], i == 5, 0, 1'b1, 60);
        wait_done();

        // Overflow: 192 accepted without last, the 193rd is refused
        pulse_start();
        for (i = 0; i < 192; i++)
            send(VB'((i * 7) % 255), i[2], 1'b0, 0, 1'b1, 60);
        send(VB'(3), 1'b0, 1'b0, 0, 1'b0, 6);
        chk("overflow_error", SW'(error), SW'(1));
        chk("overflow_ready", SW'(lit_ready), SW'(0));
        repeat (5) @(negedge clk);
        chk("error_sticky", SW'(error), SW'(1));
        chk("overflow_writes", SW'(wr_cnt), SW'(exp_wr));
        pulse_start();
        for (i = 0; i < 3; i++)
            send(VB'(100 + i), 1'b1, i == 2, 0, 1'b1, 60);
        wait_done();

        // Backpressure: random idle gaps over one full slice
        pulse_start();
        for (i = 0; i < 48; i++)
            send(VB'($urandom_range(0, 254)), 1'($urandom), 1'b0,
                 int'($urandom_range(0, 1)), 1'b1, 60);
        // Reset in the middle of the second slice
        for (i = 0; i < 20; i++)
            send(VB'(200 + i), 1'b0, 1'b0, 0, 1'b1, 60);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", SW'(lit_ready), SW'(0));
        chk("midrst_wr_en", SW'(mem_wr_en), SW'(0));
        chk("midrst_flags", SW'({busy, done, error}), SW'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_writes", SW'(wr_cnt), SW'(exp_wr));
        pulse_start();
        for (i = 0; i < 4; i++)
            send(VB'(50 + i), 1'b0, i == 3, 0, 1'b1, 60);
        wait_done();

        // Start pulsed mid-load must be ignored
        pulse_start();
        for (i = 0; i < 10; i++)
            send(VB'(i * 3), i[0], 1'b0, 0, 1'b1, 60);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", SW'(busy), SW'(1));
        for (i = 10; i < 48; i++)
            send(VB'(i * 3), i[0], i == 47, 0, 1'b1, 60);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
